// File: rtl/crono_pkg.sv
// Purpose : shared types and timing constants for the stopwatch front end.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package crono_pkg;

    localparam int CLK_HZ        = 100_000_000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;   // 10 ms of core clock
    localparam int LONG_2S       = 2 * CLK_HZ;     // 2 s of core clock

    // Press-duration FSM states of the button conditioner.
    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        LONG_HELD,
        DB_REL
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose : two-flop synchronizer bringing asynchronous inputs into the clk domain.
// Latency : 2 clk edges from input capture to output.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-low reset, clears both stages
//   d    - asynchronous input bus (bits are synchronized independently)
//   q    - synchronized output
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Both stages carry ASYNC_REG so placement keeps them adjacent and
    // timing analysis treats the first stage as a metastability catcher.
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= '0;
            stable <= '0;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/button_conditioner.sv
// Purpose : turns a raw bouncing push-button into a clean level and one-cycle press/release/long-hold events.
// Latency : press and level rise DEBOUNCE_CYCLES+2 edges after the button is first sampled high; release likewise.
// Backpressure: none; events are single-cycle pulses and are not held for a consumer.
//
// Ports:
//   clk           - system clock
//   rst           - asynchronous active-low reset
//   button        - raw asynchronous push-button, active-high
//   level         - debounced button level
//   press         - one-cycle pulse when a debounced press is accepted
//   release_short - one-cycle pulse on debounced release of a hold that never went long
//   long_press    - one-cycle pulse when a hold reaches LONG_CYCLES
//   busy          - high whenever the FSM is not IDLE
module button_conditioner
    import crono_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_2S
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_short,
    output logic long_press,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);

    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic          s;
    btn_state_t    state;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          long_seen;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_seen     <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_short <= 1'b0;
            long_press    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Event outputs are pulses: cleared every cycle unless set below.
            press         <= 1'b0;
            release_short <= 1'b0;
            long_press    <= 1'b0;

            case (state)
                IDLE: begin
                    if (s) begin
                        state   <= DB_PRESS;
                        deb_cnt <= DEB_ONE;
                        busy    <= 1'b1;
                    end
                end

                DB_PRESS: begin
                    if (!s) begin
                        // Too short to be a press: drop it silently.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= PRESSED;
                        press     <= 1'b1;
                        level     <= 1'b1;
                        hold_cnt  <= '0;
                        long_seen <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end

                PRESSED: begin
                    // A low sample wins over the long threshold in the same cycle.
                    if (!s) begin
                        state   <= DB_REL;
                        deb_cnt <= DEB_ONE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= LONG_HELD;
                        long_press <= 1'b1;
                        long_seen  <= 1'b1;
                    end else begin
                        // Only reachable below HOLD_LAST, so the counter saturates.
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end

                LONG_HELD: begin
                    if (!s) begin
                        state   <= DB_REL;
                        deb_cnt <= DEB_ONE;
                    end
                end

                DB_REL: begin
                    if (s) begin
                        // Release bounce: resume the hold where it left off.
                        state <= long_seen ? LONG_HELD : PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        busy          <= 1'b0;
                        release_short <= !long_seen;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic button = 1'b0;
    logic level, press, release_short, long_press, busy;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .level         (level),
        .press         (press),
        .release_short (release_short),
        .long_press    (long_press),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, phrased in terms of sample history:
    //  - the FSM sees the button value sampled two edges earlier;
    //  - the level flips after D consecutive seen samples that differ from it;
    //  - while held and not yet long, every edge whose seen sample and the
    //    previous seen sample are both high adds one unit of hold time;
    //    the L-th unit fires long_press;
    //  - the conditioner is busy when level is high or the seen sample is high.
    logic m_s1, m_s2, m_prev, m_level, m_long;
    int   m_run, m_hold;
    logic e_press, e_rel, e_long, e_busy;

    int edge_no;
    int n_press, n_rel, n_long;
    int at_press, at_rel, at_long;

    typedef struct {
        string name;
        string pat;
        int    n_press;
        int    n_rel;
        int    n_long;
        int    press_at;
        int    rel_at;
        int    long_at;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_prev = 0; m_level = 0; m_long = 0;
        m_run = 0; m_hold = 0;
        e_press = 0; e_rel = 0; e_long = 0; e_busy = 0;
    endtask

    task automatic model_edge(input logic b);
        logic s_now;
        s_now = m_s2;
        m_s2  = m_s1;
        m_s1  = b;
        e_press = 0; e_rel = 0; e_long = 0;
        if (m_level && !m_long && s_now && m_prev) begin
            m_hold++;
            if (m_hold == L) begin
                e_long = 1;
                m_long = 1;
            end
        end
        if (s_now != m_level) m_run++;
        else                  m_run = 0;
        if (m_run == D) begin
            m_run   = 0;
            m_level = !m_level;
            if (m_level) begin
                e_press = 1;
                m_hold  = 0;
                m_long  = 0;
            end else begin
                e_rel = !m_long;
            end
        end
        m_prev = s_now;
        e_busy = m_level | s_now;
    endtask

    task automatic clear_stats();
        edge_no = 0;
        n_press = 0; n_rel = 0; n_long = 0;
        at_press = -1; at_rel = -1; at_long = -1;
    endtask

    // Drive b for the next edge, advance the model, then compare 1 ns after the edge.
    task automatic tick(input logic b);
        button = b;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge(b);
        edge_no++;
        #1;
        check("outputs", {27'd0, level, press, release_short, long_press, busy},
                         {27'd0, m_level, e_press, e_rel, e_long, e_busy});
        check("one_pulse", (int'(press) + int'(release_short) + int'(long_press)) > 1, 0);
        if (press)         begin n_press++; if (at_press < 0) at_press = edge_no; end
        if (release_short) begin n_rel++;   if (at_rel   < 0) at_rel   = edge_no; end
        if (long_press)    begin n_long++;  if (at_long  < 0) at_long  = edge_no; end
    endtask

    function automatic string rep(input string c, input int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, c};
        return r;
    endfunction

    task automatic set_vec(input int idx, input string name, input string pat,
                           input int np, input int nr, input int nl,
                           input int pa, input int ra, input int la);
        vecs[idx].name     = name;
        vecs[idx].pat      = pat;
        vecs[idx].n_press  = np;
        vecs[idx].n_rel    = nr;
        vecs[idx].n_long   = nl;
        vecs[idx].press_at = pa;
        vecs[idx].rel_at   = ra;
        vecs[idx].long_at  = la;
    endtask

    initial begin
        // Edge numbers count from the first edge of each pattern (edge 1).
        set_vec(0, "clean",  {rep("1", 10), rep("0", 10)},            1, 1, 0,  6, 16, -1);
        set_vec(1, "glitch", {"11", rep("0", 8)},                      0, 0, 0, -1, -1, -1);
        set_vec(2, "bounce", {"10101", rep("1", 8), "010", rep("0", 10)}, 1, 1, 0, 10, 21, -1);
        set_vec(3, "long",   {rep("1", 40), rep("0", 10)},            1, 0, 1,  6, -1, 26);
        set_vec(4, "race",   {rep("1", 23), rep("0", 10)},            1, 1, 0,  6, 29, -1);
        set_vec(5, "justlong", {rep("1", 24), rep("0", 10)},          1, 0, 1,  6, -1, 26);

        model_reset();
        clear_stats();

        // Reset state, with the clock running.
        rst = 0;
        button = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {27'd0, level, press, release_short, long_press, busy}, 0);
        rst = 1;   // released just after an edge, i.e. synchronous to clk

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            clear_stats();
            for (int j = 0; j < vecs[v].pat.len(); j++)
                tick(vecs[v].pat[j] == "1");
            check({vecs[v].name, "_n_press"},  n_press,  vecs[v].n_press);
            check({vecs[v].name, "_n_rel"},    n_rel,    vecs[v].n_rel);
            check({vecs[v].name, "_n_long"},   n_long,   vecs[v].n_long);
            check({vecs[v].name, "_press_at"}, at_press, vecs[v].press_at);
            check({vecs[v].name, "_rel_at"},   at_rel,   vecs[v].rel_at);
            check({vecs[v].name, "_long_at"},  at_long,  vecs[v].long_at);
            check({vecs[v].name, "_idle"}, {30'd0, level, busy}, 0);
        end

        // Asynchronous reset while PRESSED, applied between clock edges.
        clear_stats();
        repeat (10) tick(1'b1);
        check("pre_rst_level", level, 1);
        #3;
        rst = 0;
        #1;
        check("rst_async", {27'd0, level, press, release_short, long_press, busy}, 0);
        model_reset();
        repeat (3) tick(1'b1);
        rst = 1;
        // Button still high across reset release: a fresh full debounce is needed.
        clear_stats();
        repeat (12) tick(1'b1);
        check("rst_hold_press_at", at_press, 6);
        check("rst_hold_n_press",  n_press,  1);
        repeat (10) tick(1'b0);
        check("rst_hold_n_rel", n_rel, 1);

        // Randomized segments checked cycle by cycle against the model.
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            logic val;
            val = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 35) : $urandom_range(1, 6);
            repeat (len) tick(val);
        end
        repeat (12) tick(1'b0);
        check("random_end_idle", {30'd0, level, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
